// File: rtl/score_keeper.sv
// Point-scoring engine for the ping-pong game: turns miss events into player
// scores and sequences the serve pause and ball release.
module score_keeper #(
  parameter int unsigned WIN_SCORE = 11,
  parameter int unsigned PAUSE_MS  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic [1:0] game_state,
  input  logic       p1_miss,
  input  logic       p2_miss,
  input  logic       new_game,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       serve_player,
  output logic       ball_release,
  output logic       serve_wait
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_WAIT,
    PLAY,
    POINT,
    OVER
  } state_t;

  state_t      state, state_next;
  logic        ms_sync1, ms_sync2, ms_prev;
  logic        p1_prev, p2_prev, ng_prev;
  logic [15:0] pause_cnt, cnt_next;
  logic        winner, winner_next;  // 1: player 2 won the point
  logic        release_req, release_next;
  logic        tick, p1_ev, p2_ev, ng_ev;
  logic [3:0]  pt_score, pt_new;
  logic        pt_reached;

  assign tick  = ms_sync2 & ~ms_prev;
  assign p1_ev = p1_miss & ~p1_prev;
  assign p2_ev = p2_miss & ~p2_prev;
  assign ng_ev = new_game & ~ng_prev;

  assign pt_score   = winner ? p2_score : p1_score;
  assign pt_new     = (pt_score < 4'(WIN_SCORE)) ? pt_score + 4'd1 : pt_score;
  assign pt_reached = (pt_new == 4'(WIN_SCORE));

  assign serve_wait = (state == SERVE_WAIT);

  always_comb begin
    state_next   = state;
    cnt_next     = pause_cnt;
    winner_next  = winner;
    release_req  = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE: begin
        if (game_state == 2'b01) state_next = SERVE_WAIT;
      end
      SERVE_WAIT: begin
        if (tick) begin
          if (pause_cnt == 16'(PAUSE_MS - 1)) begin
            release_req = 1'b1;
            state_next  = PLAY;
          end else begin
            cnt_next = pause_cnt + 16'd1;
          end
        end
      end
      PLAY: begin
        if (p1_ev && p2_ev) begin
          state_next = SERVE_WAIT;
        end else if (p1_ev) begin
          winner_next = 1'b1;
          state_next  = POINT;
        end else if (p2_ev) begin
          winner_next = 1'b0;
          state_next  = POINT;
        end
      end
      POINT: begin
        state_next = pt_reached ? OVER : SERVE_WAIT;
      end
      OVER: begin
        if (ng_ev) state_next = SERVE_WAIT;
      end
      default: state_next = IDLE;
    endcase

    if (game_state == 2'b00) state_next = IDLE;
    else if (game_state[1] && state != POINT) state_next = OVER;

    // The counter only lives inside SERVE_WAIT, so every entry starts a fresh
    // pause; a release cancelled by a game_state override never pulses.
    if (state_next != SERVE_WAIT) cnt_next = '0;
    release_next = release_req && (state_next == PLAY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      ms_sync1     <= 1'b0;
      ms_sync2     <= 1'b0;
      ms_prev      <= 1'b0;
      p1_prev      <= 1'b0;
      p2_prev      <= 1'b0;
      ng_prev      <= 1'b0;
      pause_cnt    <= '0;
      winner       <= 1'b0;
      p1_score     <= '0;
      p2_score     <= '0;
      serve_player <= 1'b0;
      ball_release <= 1'b0;
    end else begin
      state        <= state_next;
      ms_sync1     <= clk_1ms;
      ms_sync2     <= ms_sync1;
      ms_prev      <= ms_sync2;
      p1_prev      <= p1_miss;
      p2_prev      <= p2_miss;
      ng_prev      <= new_game;
      pause_cnt    <= cnt_next;
      winner       <= winner_next;
      ball_release <= release_next;
      if (state == POINT) begin
        if (winner) p2_score <= pt_new;
        else        p1_score <= pt_new;
        serve_player <= ~winner;
      end else if (state == OVER && ng_ev) begin
        p1_score     <= '0;
        p2_score     <= '0;
        serve_player <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a 3-tick serve pause and hand-computed
// expectations.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_1ms;
  logic [1:0] game_state;
  logic       p1_miss, p2_miss, new_game;
  logic [3:0] p1_score, p2_score;
  logic       serve_player, ball_release, serve_wait;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned rel_cnt = 0;
  int unsigned rel_snap;

  score_keeper #(.WIN_SCORE(11), .PAUSE_MS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_1ms      (clk_1ms),
    .game_state   (game_state),
    .p1_miss      (p1_miss),
    .p2_miss      (p2_miss),
    .new_game     (new_game),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .serve_player (serve_player),
    .ball_release (ball_release),
    .serve_wait   (serve_wait)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ball_release) rel_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    clk_1ms = 1'b1;
    repeat (4) step();
    clk_1ms = 1'b0;
    repeat (4) step();
  endtask

  task automatic serve();
    repeat (3) tick();
  endtask

  // to_p1: point goes to player 1 (player 2 misses)
  task automatic point(input bit to_p1);
    serve();
    if (to_p1) p2_miss = 1'b1;
    else       p1_miss = 1'b1;
    step();
    p1_miss = 1'b0;
    p2_miss = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0; clk_1ms = 1'b0; game_state = 2'b00;
    p1_miss = 1'b0; p2_miss = 1'b0; new_game = 1'b0;
    step(); step();
    check("rst_p1", p1_score, 0);
    check("rst_p2", p2_score, 0);
    check("rst_sp", serve_player, 0);
    check("rst_br", ball_release, 0);
    check("rst_sw", serve_wait, 0);

    reset = 1'b1; game_state = 2'b01;
    step();
    check("enter_sw", serve_wait, 1);

    tick(); tick();
    check("no_early_rel", rel_cnt, 0);
    clk_1ms = 1'b1;
    step(); step();
    check("rel_not_yet", ball_release, 0);
    step();
    check("rel_pulse", ball_release, 1);
    check("rel_play", serve_wait, 0);
    step();
    check("rel_one_clk", ball_release, 0);
    clk_1ms = 1'b0;
    repeat (4) step();
    check("rel_count1", rel_cnt, 1);

    p2_miss = 1'b1;
    step();
    check("miss_lat_p1", p1_score, 0);
    p2_miss = 1'b0;
    step();
    check("p2miss_p1", p1_score, 1);
    check("p2miss_p2", p2_score, 0);
    check("p2miss_sp", serve_player, 1);
    check("p2miss_sw", serve_wait, 1);

    // miss rising in SERVE_WAIT and held across release must not score
    p1_miss = 1'b1;
    serve();
    check("held_p1", p1_score, 1);
    check("held_p2", p2_score, 0);
    check("held_play", serve_wait, 0);
    check("rel_count2", rel_cnt, 2);
    p1_miss = 1'b0;
    step();

    p1_miss = 1'b1; p2_miss = 1'b1;
    step();
    p1_miss = 1'b0; p2_miss = 1'b0;
    step();
    check("let_p1", p1_score, 1);
    check("let_p2", p2_score, 0);
    check("let_sp", serve_player, 1);
    check("let_sw", serve_wait, 1);

    point(1'b0);
    check("p1miss_p2", p2_score, 1);
    check("p1miss_sp", serve_player, 0);

    repeat (9) point(1'b1);
    check("run_p1", p1_score, 10);
    check("run_p2", p2_score, 1);

    serve();
    p2_miss = 1'b1;
    step();
    p2_miss = 1'b0;
    step();
    check("win_p1", p1_score, 11);
    check("win_over", serve_wait, 0);
    check("win_sp", serve_player, 1);
    game_state = 2'b10;
    step();
    p1_miss = 1'b1; step(); p1_miss = 1'b0; step();
    p2_miss = 1'b1; step(); p2_miss = 1'b0; step();
    repeat (3) step();
    check("frozen_p1", p1_score, 11);
    check("frozen_p2", p2_score, 1);
    check("frozen_sp", serve_player, 1);
    check("frozen_sw", serve_wait, 0);

    game_state = 2'b01;
    step();
    check("over_hold", serve_wait, 0);
    new_game = 1'b1;
    step();
    check("ng_p1", p1_score, 0);
    check("ng_p2", p2_score, 0);
    check("ng_sp", serve_player, 0);
    check("ng_sw", serve_wait, 1);
    point(1'b0);
    step();
    check("ng_held_p2", p2_score, 1);
    check("ng_held_p1", p1_score, 0);
    new_game = 1'b0;

    repeat (5) point(1'b1);
    repeat (6) point(1'b0);
    check("mid_p1", p1_score, 5);
    check("mid_p2", p2_score, 7);
    check("mid_sw", serve_wait, 1);
    rel_snap = rel_cnt;
    tick(); tick();
    clk_1ms = 1'b1;
    step(); step();
    reset = 1'b0; clk_1ms = 1'b0;
    step();
    check("mr_p1", p1_score, 0);
    check("mr_p2", p2_score, 0);
    check("mr_sp", serve_player, 0);
    check("mr_sw", serve_wait, 0);
    check("mr_br", ball_release, 0);
    repeat (4) step();
    check("mr_no_rel", rel_cnt, rel_snap);
    reset = 1'b1;
    step();
    check("mr_restart", serve_wait, 1);
    p2_miss = 1'b1; step(); p2_miss = 1'b0; step();
    check("sw_miss_p1", p1_score, 0);

    serve();
    check("gs0_play", serve_wait, 0);
    game_state = 2'b00;
    step();
    check("gs0_idle", serve_wait, 0);
    game_state = 2'b01;
    step();
    check("gs0_resume", serve_wait, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Point-scoring engine for the ping-pong game. Converts miss events from the ball/paddle logic into the two 4-bit player scores consumed by the game-state block, and sequences serve pauses and ball release through a small FSM. Scoring freezes once a winner is declared, and resumes only on a new-game request.

## Interface
- WIN_SCORE, 11: winning score; scores never exceed it.
- PAUSE_MS, 1000: number of ms ticks in the pre-serve pause (≥1).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- clk_1ms  in  1  slow 1 ms square wave; its rising edges are the ms tick.
- game_state  in  2  00 reset, 01 playing, 10 p1 won, 11 p2 won.
- p1_miss  in  1  ball passed player 1's paddle (level, clk domain); point to p2.
- p2_miss  in  1  ball passed player 2's paddle; point to p1.
- new_game  in  1  restart request (level, clk domain).
- p1_score  out  4  player 1 score, 0..WIN_SCORE.
- p2_score  out  4  player 2 score, 0..WIN_SCORE.
- serve_player  out  1  0 = p1 serves, 1 = p2 serves.
- ball_release  out  1  one-cycle pulse: ball leaves the server.
- serve_wait  out  1  high while in SERVE_WAIT.

## Operation
- Reset (reset==0 at an edge): state IDLE; p1_score=0, p2_score=0, serve_player=0, ball_release=0, serve_wait=0; pause counter=0; all edge-detect history registers=0. Reset overrides every other input.
- ms tick: clk_1ms passes through a 2-flop synchronizer. Tick = synchronized high AND previous synchronized low. Width is 1 clk.
- Edge detect: p1_miss, p2_miss and new_game each have a previous-sample register that updates every cycle in every state. An event is a current-high, previous-low pair.
- IDLE: go to SERVE_WAIT when game_state==01.
- SERVE_WAIT: serve_wait=1.
  - Pause counter increments on each tick.
  - On the tick that takes it to PAUSE_MS: pulse ball_release, clear the counter, go to PLAY.
  - Miss events are ignored.
- PLAY: a miss event latches the point winner and moves to POINT.
  - p1_miss wins the point for p2. p2_miss wins it for p1.
  - p1_miss and p2_miss events in the same cycle are a let: no point, go to SERVE_WAIT, server unchanged.
- POINT (1 cycle):
  - Increment the winner's score.
  - serve_player becomes the point loser.
  - If the new score equals WIN_SCORE, go to OVER. Otherwise go to SERVE_WAIT.
- OVER: scores and serve_player are frozen; miss events are ignored. A new_game event clears both scores, sets serve_player=0 and goes to SERVE_WAIT.
- game_state override:
  - game_state 10 or 11 in any state other than POINT forces OVER.
  - game_state 00 forces IDLE with scores held.
- Width: scores are 4-bit unsigned and saturate at WIN_SCORE; they cannot wrap. Pause counter is 16-bit.
- new_game outside OVER is ignored.

## Timing
- Miss latency: miss first sampled high at edge k in PLAY → state POINT after edge k. Score and serve_player update after edge k+1.
- Game-over path: p1_score/p2_score reach WIN_SCORE after edge k+1. The game-state block flags the winner one cycle later, when this block is already in OVER.
- Pause length: ball_release asserts for exactly one clk in the cycle after the PAUSE_MS-th tick edge following SERVE_WAIT entry. Ticks already in flight at entry do not count toward the pause.
- Tick latency: a clk_1ms rise reaches the pause counter 3 clk later (2 synchronizer flops + edge register).
- A miss held high across SERVE_WAIT→PLAY does not score. It must fall and rise again.
- new_game in OVER: scores read 0 after the edge that samples the event.
- Reset mid-operation clears everything at that edge. No ball_release pulse is generated.

## Test plan
- Reset, then game_state=01: all outputs 0, then SERVE_WAIT. With PAUSE_MS=3, ball_release pulses once after the 3rd tick.
- In PLAY, pulse p2_miss: p1_score 0→1 two edges after the sample; serve_player=1; serve_wait rises; p2_score stays 0.
- Simultaneous p1_miss/p2_miss rising in PLAY: scores unchanged, serve_player unchanged, re-enters SERVE_WAIT.
- p1 at 10, p2_miss event: p1_score=11, state OVER. Further misses leave scores at 11/x. game_state=10 is held without change.
- In OVER, new_game rises: both scores 0, serve_player 0, serve_wait=1. new_game held high gives no second clear.
- Assert reset mid-SERVE_WAIT with scores 5/7: next edge scores 0/0, no ball_release. A miss during SERVE_WAIT scores nothing.
